// File: rtl/aui_tx_scheduler.sv
// AUI transmit scheduler: pairs transcoded blocks onto two flows and
// opens an alignment-marker window every AM_PERIOD accepted blocks.
module aui_tx_scheduler #(
    parameter int BITS_BLOCK = 257,
    parameter int AM_PERIOD  = 64,
    parameter int AM_SLOTS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enable,
    input  logic                  i_valid,
    input  logic [BITS_BLOCK-1:0] i_block,
    output logic                  o_ready,
    output logic [BITS_BLOCK-1:0] o_flow_0,
    output logic [BITS_BLOCK-1:0] o_flow_1,
    output logic                  o_flow_valid,
    output logic                  o_am_insert,
    output logic                  o_busy,
    output logic [15:0]           o_period_count
);

    localparam int BW = $clog2(AM_PERIOD);
    localparam int SW = (AM_SLOTS > 1) ? $clog2(AM_SLOTS) : 1;
    localparam logic [BW-1:0] BLK_LAST  = BW'(AM_PERIOD - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(AM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        AM,
        DATA
    } state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   blk_cnt, blk_cnt_nxt;
    logic [SW-1:0]   slot_cnt, slot_cnt_nxt;
    logic            phase, phase_nxt;
    logic            accept;
    logic            am_exit;
    logic [BITS_BLOCK-1:0] hold;

    assign accept = i_valid & o_ready;

    always_comb begin
        state_nxt    = state;
        blk_cnt_nxt  = blk_cnt;
        slot_cnt_nxt = slot_cnt;
        phase_nxt    = phase;
        am_exit      = 1'b0;
        unique case (state)
            IDLE: begin
                blk_cnt_nxt  = '0;
                slot_cnt_nxt = '0;
                phase_nxt    = 1'b0;
                if (i_enable) begin
                    state_nxt = AM;
                end
            end
            AM: begin
                if (slot_cnt == SLOT_LAST) begin
                    slot_cnt_nxt = '0;
                    am_exit      = 1'b1;
                    state_nxt    = i_enable ? DATA : IDLE;
                end else begin
                    slot_cnt_nxt = slot_cnt + 1'b1;
                end
            end
            DATA: begin
                if (accept) begin
                    phase_nxt = ~phase;
                    if (blk_cnt == BLK_LAST) begin
                        blk_cnt_nxt = '0;
                    end else begin
                        blk_cnt_nxt = blk_cnt + 1'b1;
                    end
                end
                // Leave only on a pair boundary so no half pair is stranded
                if (accept && blk_cnt == BLK_LAST) begin
                    state_nxt = AM;
                end else if (!i_enable && !phase_nxt) begin
                    state_nxt   = IDLE;
                    blk_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            blk_cnt        <= '0;
            slot_cnt       <= '0;
            phase          <= 1'b0;
            hold           <= '0;
            o_ready        <= 1'b0;
            o_am_insert    <= 1'b0;
            o_busy         <= 1'b0;
            o_flow_valid   <= 1'b0;
            o_flow_0       <= '0;
            o_flow_1       <= '0;
            o_period_count <= '0;
        end else begin
            state        <= state_nxt;
            blk_cnt      <= blk_cnt_nxt;
            slot_cnt     <= slot_cnt_nxt;
            phase        <= phase_nxt;
            o_ready      <= (state_nxt == DATA);
            o_am_insert  <= (state_nxt == AM);
            o_busy       <= (state_nxt != IDLE);
            o_flow_valid <= accept & phase;
            if (accept && !phase) begin
                hold <= i_block;
            end
            if (accept && phase) begin
                o_flow_0 <= hold;
                o_flow_1 <= i_block;
            end
            if (am_exit) begin
                o_period_count <= o_period_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_aui_tx_scheduler.sv
// Scoreboard bench for aui_tx_scheduler: pair routing, AM windows,
// bubbles, enable drop, reset aborts and period counter wrap.
module tb_aui_tx_scheduler;

    localparam int W = 257;

    logic         clk = 1'b0;
    logic         rst, en, vld;
    logic [W-1:0] blk;
    logic         o_ready, o_flow_valid, o_am_insert, o_busy;
    logic [W-1:0] o_flow_0, o_flow_1;
    logic [15:0]  o_period_count;

    logic         w_rst, w_en, w_vld;
    logic [W-1:0] w_blk;
    logic         w_ready, w_fv, w_am, w_busy;
    logic [W-1:0] w_f0, w_f1;
    logic [15:0]  w_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aui_tx_scheduler #(.BITS_BLOCK(W), .AM_PERIOD(4), .AM_SLOTS(2)) dut (
        .clk(clk), .rst(rst), .i_enable(en), .i_valid(vld),
        .i_block(blk), .o_ready(o_ready), .o_flow_0(o_flow_0),
        .o_flow_1(o_flow_1), .o_flow_valid(o_flow_valid),
        .o_am_insert(o_am_insert), .o_busy(o_busy),
        .o_period_count(o_period_count)
    );

    aui_tx_scheduler #(.BITS_BLOCK(W), .AM_PERIOD(2), .AM_SLOTS(1)) u_wrap (
        .clk(clk), .rst(w_rst), .i_enable(w_en), .i_valid(w_vld),
        .i_block(w_blk), .o_ready(w_ready), .o_flow_0(w_f0),
        .o_flow_1(w_f1), .o_flow_valid(w_fv),
        .o_am_insert(w_am), .o_busy(w_busy),
        .o_period_count(w_cnt)
    );

    // Scoreboard: expected pairs pushed on odd acceptances, popped on pulse
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] e;
    logic [W-1:0]   m_hold;
    logic           m_phase = 1'b0;
    logic           pend = 1'b0;
    logic           am_next = 1'b0;
    int             m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 1'b0;
            m_cnt   = 0;
            pend    = 1'b0;
            am_next = 1'b0;
            exp_q.delete();
        end else begin
            pend    = 1'b0;
            am_next = 1'b0;
            if (vld && o_ready) begin
                if (!m_phase) begin
                    m_hold = blk;
                end else begin
                    exp_q.push_back({m_hold, blk});
                    pend = 1'b1;
                end
                m_phase = ~m_phase;
                if (m_cnt == 3) begin
                    m_cnt   = 0;
                    am_next = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
        n_tests++;
        if (o_flow_valid !== pend) begin
            n_fail++;
            $display("FAIL sb_pulse: o_flow_valid=%b want %b t=%0t",
                     o_flow_valid, pend, $time);
        end
        if (pend && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if ({o_flow_0, o_flow_1} !== e) begin
                n_fail++;
                $display("FAIL sb_pair: got %0h/%0h want %0h/%0h",
                         o_flow_0, o_flow_1, e[2*W-1:W], e[W-1:0]);
            end
        end
        if (am_next) begin
            n_tests++;
            if (o_am_insert !== 1'b1 || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_am_after_period: am=%b ready=%b want 1/0",
                         o_am_insert, o_ready);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b0;
        vld = 1'b0;
        blk = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (o_ready !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: o_ready=%b want 1", tag, o_ready);
        end
    endtask

    task automatic send(input logic [W-1:0] v);
        int   k = 0;
        logic a;
        blk = v;
        vld = 1'b1;
        do begin
            a = o_ready;
            tick();
            k++;
        end while (!a && k < 20);
        vld = 1'b0;
        if (!a) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: block %0h got no ready, want ready", v);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        vld = 1'b1;
        blk = W'(5);
        tick();
        tick();
        n_tests++;
        if ({o_ready, o_am_insert, o_flow_valid, o_busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rdy/am/fv/busy=%b want 0000",
                     {o_ready, o_am_insert, o_flow_valid, o_busy});
        end
        n_tests++;
        if (o_flow_0 !== '0 || o_flow_1 !== '0) begin
            n_fail++;
            $display("FAIL reset_flow: got %0h/%0h want 0/0", o_flow_0, o_flow_1);
        end
        n_tests++;
        if (o_period_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", o_period_count);
        end
        do_reset();
    endtask

    task automatic test_startup;
        do_reset();
        en  = 1'b1;
        vld = 1'b1;
        blk = W'(1);
        for (int s = 0; s < 2; s++) begin
            tick();
            n_tests++;
            if (o_am_insert !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL start_am%0d: am/rdy/busy=%b%b%b want 101",
                         s, o_am_insert, o_ready, o_busy);
            end
        end
        tick();
        n_tests++;
        if (o_ready !== 1'b1 || o_am_insert !== 1'b0 || o_period_count !== 16'd1) begin
            n_fail++;
            $display("FAIL start_data: rdy=%b am=%b cnt=%0d want 1 0 1",
                     o_ready, o_am_insert, o_period_count);
        end
        for (int i = 1; i <= 4; i++) begin
            send(W'(i));
        end
        n_tests++;
        if (o_am_insert !== 1'b1 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_am2: am=%b rdy=%b want 1 0", o_am_insert, o_ready);
        end
        tick();
        tick();
        n_tests++;
        if (o_ready !== 1'b1 || o_period_count !== 16'd2) begin
            n_fail++;
            $display("FAIL start_cnt2: rdy=%b cnt=%0d want 1 2", o_ready, o_period_count);
        end
    endtask

    task automatic test_pairing;
        do_reset();
        en = 1'b1;
        wait_ready("pair");
        send(W'(1));
        n_tests++;
        if (o_flow_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pair_even_nopulse: fv=%b want 0", o_flow_valid);
        end
        send(W'(2));
        n_tests++;
        if (o_flow_valid !== 1'b1 || o_flow_0 !== W'(1) || o_flow_1 !== W'(2)) begin
            n_fail++;
            $display("FAIL pair_first: fv=%b %0h/%0h want 1 1/2",
                     o_flow_valid, o_flow_0, o_flow_1);
        end
        send(W'(3));
        n_tests++;
        if (o_flow_0 !== W'(1) || o_flow_1 !== W'(2)) begin
            n_fail++;
            $display("FAIL pair_hold: %0h/%0h want 1/2", o_flow_0, o_flow_1);
        end
        send(W'(4));
        n_tests++;
        if (o_flow_valid !== 1'b1 || o_flow_0 !== W'(3) || o_flow_1 !== W'(4)) begin
            n_fail++;
            $display("FAIL pair_second: fv=%b %0h/%0h want 1 3/4",
                     o_flow_valid, o_flow_0, o_flow_1);
        end
    endtask

    task automatic test_bubbles;
        do_reset();
        en = 1'b1;
        wait_ready("bub");
        for (int i = 0; i < 7; i++) begin
            if (i % 2 == 0) begin
                send(W'(16 + i));
            end else begin
                vld = 1'b0;
                tick();
                n_tests++;
                if (o_flow_valid !== 1'b0 || o_ready !== 1'b1 || o_am_insert !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bubble%0d: fv/rdy/am=%b%b%b want 010",
                             i, o_flow_valid, o_ready, o_am_insert);
                end
            end
        end
        n_tests++;
        if (o_am_insert !== 1'b1 || o_period_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bubble_am: am=%b cnt=%0d want 1 1", o_am_insert, o_period_count);
        end
    endtask

    task automatic test_enable_drop;
        do_reset();
        en = 1'b1;
        wait_ready("drop");
        send(W'(1));
        en = 1'b0;
        n_tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_midpair: rdy=%b busy=%b want 1 1", o_ready, o_busy);
        end
        send(W'(2));
        n_tests++;
        if (o_flow_valid !== 1'b1 || o_flow_0 !== W'(1) || o_flow_1 !== W'(2)) begin
            n_fail++;
            $display("FAIL drop_pair: fv=%b %0h/%0h want 1 1/2",
                     o_flow_valid, o_flow_0, o_flow_1);
        end
        n_tests++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_idle: busy=%b rdy=%b want 0 0", o_busy, o_ready);
        end
        tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_am_insert !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_stay: busy=%b am=%b want 0 0", o_busy, o_am_insert);
        end
        en = 1'b1;
        wait_ready("drop2");
        en = 1'b0;
        tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_even: busy=%b rdy=%b want 0 0", o_busy, o_ready);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        en = 1'b1;
        tick();
        tick();
        n_tests++;
        if (o_am_insert !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_slot2: am=%b want 1", o_am_insert);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if ({o_ready, o_am_insert, o_busy, o_period_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL rmid_am_clear: rdy/am/busy=%b%b%b cnt=%0d want 0",
                     o_ready, o_am_insert, o_busy, o_period_count);
        end
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            n_tests++;
            if (o_am_insert !== 1'b1 || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_restart%0d: am=%b rdy=%b want 1 0",
                         s, o_am_insert, o_ready);
            end
        end
        tick();
        n_tests++;
        if (o_ready !== 1'b1 || o_period_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_data: rdy=%b cnt=%0d want 1 1", o_ready, o_period_count);
        end
        send(W'(10));
        rst = 1'b1;
        tick();
        n_tests++;
        if ({o_ready, o_am_insert, o_busy, o_flow_valid} !== 4'b0 ||
            o_flow_0 !== '0 || o_flow_1 !== '0) begin
            n_fail++;
            $display("FAIL rmid_pair_clear: ctrl=%b flows=%0h/%0h want 0",
                     {o_ready, o_am_insert, o_busy, o_flow_valid}, o_flow_0, o_flow_1);
        end
        rst = 1'b0;
        en  = 1'b0;
        tick();
        tick();
        en = 1'b1;
        wait_ready("rmid");
        send(W'(11));
        send(W'(12));
        n_tests++;
        if (o_flow_valid !== 1'b1 || o_flow_0 !== W'(11) || o_flow_1 !== W'(12)) begin
            n_fail++;
            $display("FAIL rmid_newpair: fv=%b %0h/%0h want 1 11/12",
                     o_flow_valid, o_flow_0, o_flow_1);
        end
        en = 1'b0;
    endtask

    task automatic test_wrap;
        int          seen = 0;
        logic [15:0] prev;
        logic [15:0] want;
        w_rst = 1'b1;
        w_en  = 1'b0;
        w_vld = 1'b0;
        w_blk = '0;
        tick();
        w_rst = 1'b0;
        force u_wrap.o_period_count = 16'hFFFE;
        tick();
        release u_wrap.o_period_count;
        tick();
        prev  = w_cnt;
        want  = 16'hFFFF;
        w_en  = 1'b1;
        w_vld = 1'b1;
        for (int k = 0; k < 40 && seen < 2; k++) begin
            tick();
            if (w_cnt !== prev) begin
                n_tests++;
                if (w_cnt !== want) begin
                    n_fail++;
                    $display("FAIL wrap_step%0d: cnt=%0h want %0h", seen, w_cnt, want);
                end
                prev = w_cnt;
                want = want + 16'd1;
                seen++;
            end
        end
        if (seen < 2) begin
            n_tests++;
            n_fail++;
            $display("FAIL wrap_timeout: saw %0d changes want 2", seen);
        end
        w_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b0;
        vld   = 1'b0;
        blk   = '0;
        w_rst = 1'b1;
        w_en  = 1'b0;
        w_vld = 1'b0;
        w_blk = '0;
        test_reset();
        test_startup();
        test_pairing();
        test_bubbles();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
